// File: rtl/rader7_pkg.sv
// Shared constants and types for the Rader-7 transform blocks (generator g=3).
package rader7_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam int FRAME_LEN = 17;
  localparam int LOAD_LAST = 6;
  localparam int OUT_FIRST = 9;  // cycle whose edge registers the first output

  // Index 0 first: input order g^-j (5,4,6,2,3,1), output order g^i (1,3,2,6,4,5)
  localparam logic [5:0][2:0] RADER_ORD = {3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};
  localparam logic [5:0][2:0] OUT_ORD   = {3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1};

  // 256-scaled |cos| and |sin| magnitudes
  localparam int C160 = 160;
  localparam int C57  = 57;
  localparam int C231 = 231;
  localparam int S200 = 200;
  localparam int S111 = 111;
  localparam int S250 = 250;
endpackage

// File: rtl/rader7_idft_if.sv
// Sample-stream bus of the Rader-7 inverse DFT: frame input and real output.
interface rader7_idft_if #(parameter int W_IN = 11, parameter int W_OUT = W_IN + 4);
  logic                    start;
  logic signed [W_IN-1:0]  x_re;
  logic signed [W_IN-1:0]  x_im;
  logic                    busy;
  logic                    y_valid;
  logic [2:0]              y_idx;
  logic signed [W_OUT-1:0] y;

  modport master (output start, x_re, x_im, input busy, y_valid, y_idx, y);
  modport slave  (input start, x_re, x_im, output busy, y_valid, y_idx, y);
endinterface

// File: rtl/rader7_coef.sv
// Registered shift-add products x*{57,111,160,200,231,250} from shared x5/x25/x110/x125/x256 terms.
module rader7_coef #(
  parameter int W_IN = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [W_IN-1:0] x,
  output logic signed [W_IN+7:0] x57,
  output logic signed [W_IN+7:0] x111,
  output logic signed [W_IN+7:0] x160,
  output logic signed [W_IN+7:0] x200,
  output logic signed [W_IN+7:0] x231,
  output logic signed [W_IN+7:0] x250
);
  localparam int W_P = W_IN + 8;

  // Largest magnitude is 256*x, which still fits W_P bits for full-scale x
  logic signed [W_P-1:0] xe, x5, x25, x110, x125, x256;
  assign xe   = W_P'(x);
  assign x5   = (xe <<< 2) + xe;
  assign x25  = (x5 <<< 2) + x5;
  assign x110 = (x25 <<< 2) + (x5 <<< 1);
  assign x125 = (x25 <<< 2) + x25;
  assign x256 = xe <<< 8;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x57 <= '0; x111 <= '0; x160 <= '0;
      x200 <= '0; x231 <= '0; x250 <= '0;
    end else begin
      x57  <= (xe <<< 5) + x25;
      x111 <= x110 + xe;
      x160 <= x5 <<< 5;
      x200 <= x25 <<< 3;
      x231 <= x256 - x25;
      x250 <= x125 <<< 1;
    end
endmodule

// File: rtl/rader7_idft.sv
// Rader-7 inverse DFT, real part only: two transposed 6-tap FIRs (cos on Re, sin on Im) plus DC sum.
import rader7_pkg::*;

module rader7_idft #(
  parameter int W_IN  = 11,
  parameter int W_ACC = W_IN + 13,
  parameter int W_OUT = W_IN + 4
) (
  input logic         clk,
  input logic         reset,
  rader7_idft_if.slave bus
);
  localparam int W_P = W_IN + 8;

  state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;
      LOAD: if (cnt == 5'(LOAD_LAST)) state_nxt = RUN;
      RUN:  if (cnt == 5'(FRAME_LEN - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE)  cnt_nxt = '0;
    else if (state == IDLE) cnt_nxt = 5'd1;
    else                    cnt_nxt = cnt + 5'd1;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  // Input register, X[0] hold and exact DC sum
  logic signed [W_IN-1:0]  in_re, in_im, x0_re;
  logic signed [W_ACC-1:0] acc;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_re <= '0; in_im <= '0; x0_re <= '0; acc <= '0;
    end else begin
      in_re <= bus.x_re;
      in_im <= bus.x_im;
      if (state == IDLE && bus.start) begin
        x0_re <= bus.x_re;
        acc   <= W_ACC'(bus.x_re);
      end else if (state == LOAD) begin
        acc   <= acc + W_ACC'(bus.x_re);
      end
    end

  logic signed [W_P-1:0] re57, re111, re160, re200, re231, re250;
  logic signed [W_P-1:0] im57, im111, im160, im200, im231, im250;

  rader7_coef #(.W_IN(W_IN)) u_coef_re (
    .clk(clk), .reset(reset), .x(in_re),
    .x57(re57), .x111(re111), .x160(re160), .x200(re200), .x231(re231), .x250(re250)
  );
  rader7_coef #(.W_IN(W_IN)) u_coef_im (
    .clk(clk), .reset(reset), .x(in_im),
    .x57(im57), .x111(im111), .x160(im160), .x200(im200), .x231(im231), .x250(im250)
  );

  logic unused_prod;
  assign unused_prod = ^{re111, re200, re250, im57, im160, im231};

  // Tap p multiplies by W^(g^p): exponents 1,3,2,6,4,5
  logic [5:0][W_ACC-1:0] hc, hs, zc, zs;
  always_comb begin
    hc[0] =  W_ACC'(re160); hs[0] =  W_ACC'(im200);
    hc[1] = -W_ACC'(re231); hs[1] =  W_ACC'(im111);
    hc[2] = -W_ACC'(re57);  hs[2] =  W_ACC'(im250);
    hc[3] =  W_ACC'(re160); hs[3] = -W_ACC'(im200);
    hc[4] = -W_ACC'(re231); hs[4] = -W_ACC'(im111);
    hc[5] = -W_ACC'(re57);  hs[5] = -W_ACC'(im250);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      zc <= '0;
      zs <= '0;
    end else begin
      zc[5] <= hc[5];
      zs[5] <= hs[5];
      for (int k = 0; k < 5; k++) begin
        zc[k] <= hc[k] + zc[k+1];
        zs[k] <= hs[k] + zs[k+1];
      end
    end

  logic signed [W_ACC-1:0] fir_diff;
  logic signed [W_OUT-1:0] y_fir;
  logic [2:0]              osel;
  assign fir_diff = $signed(zc[0]) - $signed(zs[0]);
  assign y_fir    = W_OUT'(x0_re) + W_OUT'(fir_diff >>> 8);
  assign osel     = 3'(cnt - 5'(OUT_FIRST));

  logic                    y_valid_q;
  logic [2:0]              y_idx_q;
  logic signed [W_OUT-1:0] y_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      y_valid_q <= 1'b0; y_idx_q <= '0; y_q <= '0;
    end else if (state == RUN && cnt >= 5'(OUT_FIRST) && cnt < 5'(OUT_FIRST + 6)) begin
      y_valid_q <= 1'b1;
      y_idx_q   <= OUT_ORD[osel];
      y_q       <= y_fir;
    end else if (state == RUN && cnt == 5'(OUT_FIRST + 6)) begin
      y_valid_q <= 1'b1;
      y_idx_q   <= 3'd0;
      y_q       <= W_OUT'(acc);
    end else begin
      y_valid_q <= 1'b0;
    end

  assign bus.busy    = (state != IDLE);
  assign bus.y_valid = y_valid_q;
  assign bus.y_idx   = y_idx_q;
  assign bus.y       = y_q;
endmodule

// File: tb/tb_rader7_idft.sv
// Bench for rader7_idft: spec vectors plus random frames against a direct inverse-DFT model.
module tb_rader7_idft;
  localparam int W_IN  = 11;
  localparam int W_OUT = W_IN + 4;

  typedef int arr7_t [7];
  typedef struct {
    string name;
    arr7_t re;
    arr7_t im;
    arr7_t exp;
    bit    use_model;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  rader7_idft_if #(.W_IN(W_IN), .W_OUT(W_OUT)) bus();
  rader7_idft #(.W_IN(W_IN)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit vld_log [4096];
  bit busy_log [4096];
  int idx_log [4096];
  int y_log [4096];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (cyc < 4096) begin
      vld_log[cyc]  <= bus.y_valid;
      busy_log[cyc] <= bus.busy;
      idx_log[cyc]  <= int'(bus.y_idx);
      y_log[cyc]    <= int'(bus.y);
    end

  // Input order g^-j and output order g^i for g=3
  int rord [6] = '{5, 4, 6, 2, 3, 1};
  int oord [7] = '{1, 3, 2, 6, 4, 5, 0};
  // 256*cos(2*pi*m/7) and 256*sin(2*pi*m/7), rounded, indexed by exponent m
  int ctab [7] = '{256, 160, -57, -231, -231, -57, 160};
  int stab [7] = '{0, 200, 250, 111, -111, -250, -200};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // x[n] = Re{X0} + floor(sum_k (Re X[k]*cos - Im X[k]*sin)(nk) / 256), x[0] exact
  function automatic arr7_t model(input arr7_t re, input arr7_t im);
    arr7_t e;
    for (int n = 0; n < 7; n++) begin
      int s;
      s = 0;
      if (n == 0) begin
        for (int k = 0; k < 7; k++) s += re[k];
        e[n] = s;
      end else begin
        for (int k = 1; k < 7; k++) s += re[k] * ctab[(n * k) % 7] - im[k] * stab[(n * k) % 7];
        e[n] = re[0] + (s >>> 8);
      end
    end
    return e;
  endfunction

  function automatic int rnd_s();
    return int'($urandom_range(2047)) - 1024;
  endfunction

  task automatic set_x(input int c, input arr7_t re, input arr7_t im);
    int k;
    if (c == 0) begin
      bus.x_re = W_IN'(re[0]); bus.x_im = W_IN'(im[0]);
    end else if (c <= 11) begin
      k = rord[(c - 1) % 6];
      bus.x_re = W_IN'(re[k]); bus.x_im = W_IN'(im[k]);
    end else begin
      bus.x_re = W_IN'(rnd_s()); bus.x_im = W_IN'(rnd_s());
    end
  endtask

  task automatic drive_frame(input arr7_t re, input arr7_t im, input logic [16:0] smask,
                             output int s);
    s = 0;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      if (c == 0) s = cyc;
      bus.start = smask[c];
      set_x(c, re, im);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  function automatic int count_vld(input int a, input int b);
    int n;
    n = 0;
    for (int c = a; c <= b; c++) n += int'(vld_log[c]);
    return n;
  endfunction

  task automatic check_frame(input string name, input int s, input arr7_t exp);
    chk({name, " quiet_before"}, int'(vld_log[s + 9]), 0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("%s valid@%0d", name, 10 + i), int'(vld_log[s + 10 + i]), 1);
      chk($sformatf("%s idx@%0d", name, 10 + i), idx_log[s + 10 + i], oord[i]);
      chk($sformatf("%s x[%0d]", name, oord[i]), y_log[s + 10 + i], exp[oord[i]]);
    end
    chk({name, " busy_c1"}, int'(busy_log[s + 1]), 1);
    chk({name, " busy_c16"}, int'(busy_log[s + 16]), 1);
    chk({name, " busy_c17"}, int'(busy_log[s + 17]), 0);
  endtask

  function automatic arr7_t rnd_arr();
    arr7_t a;
    for (int k = 0; k < 7; k++) a[k] = rnd_s();
    return a;
  endfunction

  vec_t tbl [$];
  vec_t v;
  arr7_t zero7, ra, ia, rb, ib;
  int s, sa, sb;

  initial begin
    bus.start = 1'b0; bus.x_re = '0; bus.x_im = '0;
    zero7 = '{0, 0, 0, 0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #2;
    chk("reset y", int'(bus.y), 0);
    chk("reset y_valid", int'(bus.y_valid), 0);
    chk("reset y_idx", int'(bus.y_idx), 0);
    chk("reset busy", int'(bus.busy), 0);
    #3 reset = 1'b1;
    idle(2);

    v.name = "dc"; v.re = '{100, 0, 0, 0, 0, 0, 0}; v.im = zero7;
    v.exp = '{100, 100, 100, 100, 100, 100, 100}; v.use_model = 0;
    tbl.push_back(v);
    v.name = "cos"; v.re = '{0, 128, 0, 0, 0, 0, 128}; v.im = zero7;
    v.exp = '{256, 160, -57, -231, -231, -57, 160}; v.use_model = 0;
    tbl.push_back(v);
    v.name = "sin"; v.re = zero7; v.im = '{0, -128, 0, 0, 0, 0, 128};
    v.exp = '{0, 200, 250, 111, -111, -250, -200}; v.use_model = 0;
    tbl.push_back(v);
    v.name = "fullscale"; v.re = '{-1024, -1024, -1024, -1024, -1024, -1024, -1024};
    v.im = v.re; v.use_model = 1;
    tbl.push_back(v);
    for (int r = 0; r < 10; r++) begin
      v.name = $sformatf("rnd%0d", r); v.re = rnd_arr(); v.im = rnd_arr(); v.use_model = 1;
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      if (tbl[i].use_model) tbl[i].exp = model(tbl[i].re, tbl[i].im);
      drive_frame(tbl[i].re, tbl[i].im, 17'h00001, s);
      idle(4);
      check_frame(tbl[i].name, s, tbl[i].exp);
    end

    // Starts on cycles 5 and 16 must be ignored; a start on cycle 17 is taken
    ra = rnd_arr(); ia = rnd_arr(); rb = rnd_arr(); ib = rnd_arr();
    drive_frame(ra, ia, 17'h10021, sa);
    drive_frame(rb, ib, 17'h00001, sb);
    idle(4);
    check_frame("b2b_a", sa, model(ra, ia));
    chk("b2b no extra outputs", count_vld(sa + 17, sa + 26), 0);
    check_frame("b2b_b", sb, model(rb, ib));
    chk("b2b second start cycle", sb - sa, 17);

    // Reset asserted at frame cycle 8
    ra = rnd_arr(); ia = rnd_arr();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) s = cyc;
      bus.start = (c == 0);
      set_x(c, ra, ia);
    end
    reset = 1'b0;
    #1;
    chk("midrst y", int'(bus.y), 0);
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst y_valid", int'(bus.y_valid), 0);
    chk("midrst y_idx", int'(bus.y_idx), 0);
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk);
    #4 reset = 1'b1;
    idle(20);
    chk("midrst no outputs", count_vld(s + 9, s + 28), 0);
    ra = rnd_arr(); ia = rnd_arr();
    drive_frame(ra, ia, 17'h00001, s);
    idle(4);
    check_frame("after_rst", s, model(ra, ia));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
